benes_route_scheduler: RTL and testbench

Sequencer and arbiter that shares one `Interconnect_benes` instance among `N_REQ` requesters. Each requester posts a routing job: a module/slot selection plus a burst length. The scheduler grants jobs round-robin and drives the Benes select inputs for the whole burst. It gates data beats into the network, then holds the configuration until the network pipeline has drained before reconfiguring. It sits between the FHE ALU issue logic and the `Interconnect_benes` select ports.

---
 rtl/benes_route_scheduler_pkg.sv | 22 ++
 rtl/benes_route_scheduler_if.sv | 38 +++
 rtl/benes_route_scheduler_rr_arbiter.sv | 31 +++
 rtl/benes_route_scheduler.sv | 138 +++++++++++++
 tb/tb_benes_route_scheduler.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/benes_route_scheduler_pkg.sv
// Shared types for the Benes route scheduler: FSM states and the
// latched routing job that drives the network select inputs.
package benes_route_scheduler_pkg;

   localparam int BENES_MSEL_W = 8;
   localparam int BENES_SSEL_W = 8;
   localparam int BENES_LEN_W  = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_STREAM,
      S_DRAIN
   } benes_sched_state_t;

   typedef struct packed {
      logic [BENES_MSEL_W-1:0] msel;
      logic [BENES_SSEL_W-1:0] ssel;
      logic [BENES_LEN_W-1:0]  len;
   } benes_job_t;

endpackage

// File: rtl/benes_route_scheduler_if.sv
// Request, select and data-gating bundle between the ALU issue
// logic (master) and the route scheduler (slave).
interface benes_route_scheduler_if #(
   parameter int N_REQ  = 4,
   parameter int MSEL_W = 8,
   parameter int SSEL_W = 8
);
   localparam int IW = $clog2(N_REQ);

   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ*MSEL_W-1:0] req_msel;
   logic [N_REQ*SSEL_W-1:0] req_ssel;
   logic [N_REQ*8-1:0]      req_len;
   logic [MSEL_W-1:0]       o_module_select;
   logic [SSEL_W-1:0]       o_slot_select;
   logic                    o_cfg_valid;
   logic [N_REQ-1:0]        o_grant;
   logic                    dat_valid;
   logic                    dat_ready;
   logic                    dat_last;
   logic                    o_done;
   logic [IW-1:0]           o_done_id;
   logic                    o_busy;

   modport master (
      output req_valid, req_msel, req_ssel, req_len, dat_valid,
      input  req_ready, o_module_select, o_slot_select, o_cfg_valid,
      input  o_grant, dat_ready, dat_last, o_done, o_done_id, o_busy
   );

   modport slave (
      input  req_valid, req_msel, req_ssel, req_len, dat_valid,
      output req_ready, o_module_select, o_slot_select, o_cfg_valid,
      output o_grant, dat_ready, dat_last, o_done, o_done_id, o_busy
   );

endinterface

// File: rtl/benes_route_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, wrapping.
// Reusable for any shared ALU resource.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   int j;

   // Scan farthest-first so the requester nearest ptr wins last.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      j       = 0;
      for (int i = N - 1; i >= 0; i--) begin
         j = int'(ptr) + i;
         if (j >= N) j = j - N;
         if (req[j]) begin
            gnt     = '0;
            gnt[j]  = 1'b1;
            gnt_idx = IW'(j);
         end
      end
   end

endmodule

// File: rtl/benes_route_scheduler.sv
// Shares one Benes interconnect among N_REQ requesters: round-robin
// job grant, select hold, beat gating and pipeline drain.
module benes_route_scheduler
   import benes_route_scheduler_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int MSEL_W   = BENES_MSEL_W,
   parameter int SSEL_W   = BENES_SSEL_W,
   parameter int CFG_LAT  = 1,
   parameter int PIPE_LAT = 4
) (
   input logic clk,
   input logic rst,
   benes_route_scheduler_if.slave bus
);

   localparam int IW      = $clog2(N_REQ);
   localparam int MAX_LAT = (CFG_LAT > PIPE_LAT) ? CFG_LAT : PIPE_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);
   localparam logic [CW-1:0] SETTLE_LD = CW'(CFG_LAT - 1);
   localparam logic [CW-1:0] DRAIN_LD  = CW'(PIPE_LAT - 1);
   localparam logic [IW-1:0] LAST_IDX  = IW'(N_REQ - 1);

   benes_sched_state_t state;
   benes_job_t         job;

   logic [IW-1:0]     rr_ptr;
   logic [IW-1:0]     owner;
   logic [CW-1:0]     cnt;
   logic [7:0]        beat_cnt;
   logic [N_REQ-1:0]  gnt;
   logic [IW-1:0]     gnt_idx;
   logic [MSEL_W-1:0] win_msel;
   logic [SSEL_W-1:0] win_ssel;
   logic [7:0]        win_len;
   logic              hs;
   logic              beat;
   logic              last;
   logic              cfg_valid;
   logic [N_REQ-1:0]  grant;
   logic              done;
   logic [IW-1:0]     done_id;
   logic              busy;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .req     (bus.req_valid),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign win_msel = bus.req_msel[int'(gnt_idx)*MSEL_W +: MSEL_W];
   assign win_ssel = bus.req_ssel[int'(gnt_idx)*SSEL_W +: SSEL_W];
   assign win_len  = bus.req_len[int'(gnt_idx)*8 +: 8];

   // rst gates req_ready so a held request is not offered mid-reset.
   assign bus.req_ready = (state == S_IDLE && !rst) ? gnt : '0;
   assign bus.dat_ready = (state == S_STREAM);
   assign last          = (beat_cnt == job.len);
   assign bus.dat_last  = bus.dat_ready && last;

   assign hs   = |(bus.req_valid & bus.req_ready);
   assign beat = bus.dat_valid && bus.dat_ready;

   assign bus.o_module_select = MSEL_W'(job.msel);
   assign bus.o_slot_select   = SSEL_W'(job.ssel);
   assign bus.o_cfg_valid     = cfg_valid;
   assign bus.o_grant         = grant;
   assign bus.o_done          = done;
   assign bus.o_done_id       = done_id;
   assign bus.o_busy          = busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         job       <= '0;
         rr_ptr    <= '0;
         owner     <= '0;
         cnt       <= '0;
         beat_cnt  <= '0;
         cfg_valid <= 1'b0;
         grant     <= '0;
         done      <= 1'b0;
         done_id   <= '0;
         busy      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (hs) begin
                  job.msel  <= BENES_MSEL_W'(win_msel);
                  job.ssel  <= BENES_SSEL_W'(win_ssel);
                  job.len   <= win_len;
                  owner     <= gnt_idx;
                  rr_ptr    <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
                  grant     <= gnt;
                  cfg_valid <= 1'b1;
                  busy      <= 1'b1;
                  cnt       <= SETTLE_LD;
                  beat_cnt  <= '0;
                  state     <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (cnt == '0) state <= S_STREAM;
               else           cnt   <= cnt - 1'b1;
            end
            S_STREAM: begin
               // Compare before increment keeps len=255 from wrapping.
               if (beat) begin
                  if (last) begin
                     state   <= S_DRAIN;
                     cnt     <= DRAIN_LD;
                     done    <= (DRAIN_LD == '0);
                     done_id <= owner;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if (cnt == '0) begin
                  state     <= S_IDLE;
                  job       <= '0;
                  cfg_valid <= 1'b0;
                  grant     <= '0;
                  busy      <= 1'b0;
               end else begin
                  cnt  <= cnt - 1'b1;
                  done <= (cnt == CW'(1));
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_benes_route_scheduler.sv
// Scoreboard bench for benes_route_scheduler: grant order, beat
// gating, drain timing, reset abort.
module tb_benes_route_scheduler;

   localparam int N_REQ    = 4;
   localparam int MSEL_W   = 8;
   localparam int SSEL_W   = 8;
   localparam int CFG_LAT  = 1;
   localparam int PIPE_LAT = 4;

   typedef struct {
      int         id;
      logic [7:0] msel;
      logic [7:0] ssel;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   benes_route_scheduler_if #(
      .N_REQ(N_REQ), .MSEL_W(MSEL_W), .SSEL_W(SSEL_W)
   ) bus ();

   benes_route_scheduler #(
      .N_REQ(N_REQ), .MSEL_W(MSEL_W), .SSEL_W(SSEL_W),
      .CFG_LAT(CFG_LAT), .PIPE_LAT(PIPE_LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int t_hs, t_first, t_last, t_done, beats, lasts, last_no, done_id_s;
   bit hs_to, sel_chg, ready_early, busy_after, cfg_after;
   logic [7:0] s_msel, s_ssel, d_msel, d_ssel, msel_after;
   logic [3:0] s_grant;
   logic s_cfg, s_dready, done_after;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic set_req(input int id, input logic [7:0] m,
                          input logic [7:0] s, input logic [7:0] l);
      bus.req_msel[id*8 +: 8] = m;
      bus.req_ssel[id*8 +: 8] = s;
      bus.req_len[id*8 +: 8]  = l;
   endtask

   task automatic run_job(input int id, input logic [7:0] m,
                          input logic [7:0] s, input logic [7:0] l,
                          input bit gaps, input logic [3:0] raise);
      bit [4:0] pat;
      pat = 5'b11001;
      set_req(id, m, s, l);
      bus.req_valid[id] = 1'b1;
      bus.dat_valid = 1'b0;
      hs_to = 1; t_hs = -1; sel_chg = 0; ready_early = 0;
      beats = 0; lasts = 0; last_no = 0;
      t_first = -1; t_last = -1; t_done = -1; done_id_s = -1;
      for (int n = 0; n < 50; n++) begin
         #1;
         if (bus.req_ready[id]) begin
            t_hs = cyc;
            hs_to = 0;
            break;
         end
         tick();
      end
      if (hs_to) begin
         bus.req_valid[id] = 1'b0;
         return;
      end
      tick();
      bus.req_valid[id] = 1'b0;
      #1;
      s_cfg = bus.o_cfg_valid;
      s_grant = bus.o_grant;
      s_msel = bus.o_module_select;
      s_ssel = bus.o_slot_select;
      s_dready = bus.dat_ready;
      for (int n = 0; n < 400; n++) begin
         int rel;
         rel = cyc - (t_hs + 2);
         if (t_last >= 0) bus.req_valid = bus.req_valid | raise;
         bus.dat_valid = gaps ? ((rel >= 0 && rel < 5) ? pat[rel] : 1'b1) : 1'b1;
         #1;
         if (bus.o_module_select !== s_msel || bus.o_slot_select !== s_ssel)
            sel_chg = 1;
         if (t_last >= 0 && |bus.req_ready) ready_early = 1;
         if (bus.dat_valid && bus.dat_ready) begin
            beats++;
            if (t_first < 0) t_first = cyc;
            if (bus.dat_last) begin
               lasts++;
               last_no = beats;
               t_last = cyc;
            end
         end
         if (bus.o_done) begin
            t_done = cyc;
            done_id_s = int'(bus.o_done_id);
            d_msel = bus.o_module_select;
            d_ssel = bus.o_slot_select;
            break;
         end
         tick();
      end
      bus.dat_valid = 1'b0;
      tick();
      #1;
      busy_after = bus.o_busy;
      cfg_after = bus.o_cfg_valid;
      msel_after = bus.o_module_select;
      done_after = bus.o_done;
   endtask

   task automatic test_reset();
      bus.req_valid = '1;
      bus.dat_valid = 1'b1;
      tick();
      tick();
      #1;
      checks++; if (bus.req_ready !== 4'h0) begin errors++; $display("FAIL rst_req_ready got %h want 0", bus.req_ready); end
      checks++; if (bus.o_module_select !== 8'h0) begin errors++; $display("FAIL rst_msel got %h want 0", bus.o_module_select); end
      checks++; if (bus.o_slot_select !== 8'h0) begin errors++; $display("FAIL rst_ssel got %h want 0", bus.o_slot_select); end
      checks++; if (bus.o_cfg_valid !== 1'b0) begin errors++; $display("FAIL rst_cfg_valid got %b want 0", bus.o_cfg_valid); end
      checks++; if (bus.o_grant !== 4'h0) begin errors++; $display("FAIL rst_grant got %h want 0", bus.o_grant); end
      checks++; if (bus.dat_ready !== 1'b0) begin errors++; $display("FAIL rst_dat_ready got %b want 0", bus.dat_ready); end
      checks++; if (bus.dat_last !== 1'b0) begin errors++; $display("FAIL rst_dat_last got %b want 0", bus.dat_last); end
      checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", bus.o_done); end
      checks++; if (bus.o_done_id !== 2'd0) begin errors++; $display("FAIL rst_done_id got %0d want 0", bus.o_done_id); end
      checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus.o_busy); end
      bus.req_valid = '0;
      bus.dat_valid = 1'b0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_round_robin();
      int hs_t[6];
      int nhs;
      nhs = 0;
      for (int ph = 0; ph < 2; ph++) begin
         int got;
         int want;
         logic [3:0] clr;
         got = 0;
         if (ph == 0) begin
            for (int i = 0; i < 4; i++) begin
               set_req(i, 8'(8'h10 + i), 8'(8'h20 + i), 8'h00);
               sb.push_back('{i, 8'(8'h10 + i), 8'(8'h20 + i)});
            end
            bus.req_valid = 4'hF;
            want = 4;
         end else begin
            set_req(0, 8'h80, 8'h90, 8'h00);
            set_req(3, 8'h83, 8'h93, 8'h00);
            sb.push_back('{0, 8'h80, 8'h90});
            sb.push_back('{3, 8'h83, 8'h93});
            bus.req_valid = 4'b1001;
            want = 2;
         end
         bus.dat_valid = 1'b1;
         for (int n = 0; n < 200 && got < want; n++) begin
            #1;
            clr = bus.req_ready;
            if (|clr && nhs < 6) begin
               hs_t[nhs] = cyc;
               nhs++;
            end
            if (bus.o_done) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL rr_done unexpected id %0d", bus.o_done_id);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  if (int'(bus.o_done_id) != e.id || bus.o_module_select !== e.msel) begin
                     errors++;
                     $display("FAIL rr_order got id %0d msel %h want id %0d msel %h",
                              bus.o_done_id, bus.o_module_select, e.id, e.msel);
                  end
               end
               got++;
            end
            tick();
            bus.req_valid = bus.req_valid & ~clr;
         end
         checks++;
         if (got != want) begin
            errors++;
            $display("FAIL rr_timeout phase %0d got %0d dones want %0d", ph, got, want);
         end
      end
      bus.dat_valid = 1'b0;
      checks++;
      if (hs_t[1] - hs_t[0] != 1 + CFG_LAT + 1 + PIPE_LAT) begin
         errors++;
         $display("FAIL rr_cycle_time got %0d want %0d", hs_t[1] - hs_t[0], 1 + CFG_LAT + 1 + PIPE_LAT);
      end
      tick();
   endtask

   task automatic check_done_pop(input string tag);
      exp_t e;
      checks++;
      if (sb.size() == 0 || t_done < 0) begin
         errors++;
         $display("FAIL %s_done missing t_done %0d queue %0d", tag, t_done, sb.size());
      end else begin
         e = sb.pop_front();
         if (done_id_s != e.id || d_msel !== e.msel || d_ssel !== e.ssel) begin
            errors++;
            $display("FAIL %s_done got id %0d sel %h/%h want id %0d sel %h/%h",
                     tag, done_id_s, d_msel, d_ssel, e.id, e.msel, e.ssel);
         end
      end
   endtask

   task automatic test_single();
      sb.push_back('{2, 8'h15, 8'h03});
      run_job(2, 8'h15, 8'h03, 8'd3, 1'b0, 4'h0);
      checks++; if (hs_to) begin errors++; $display("FAIL single_hs got timeout want grant"); end
      checks++; if (s_cfg !== 1'b1 || s_grant !== 4'b0100) begin errors++; $display("FAIL single_cfg got %b/%b want 1/0100", s_cfg, s_grant); end
      checks++; if (s_msel !== 8'h15 || s_ssel !== 8'h03) begin errors++; $display("FAIL single_sel got %h/%h want 15/03", s_msel, s_ssel); end
      checks++; if (s_dready !== 1'b0) begin errors++; $display("FAIL single_settle got dat_ready %b want 0", s_dready); end
      checks++; if (t_first != t_hs + 2) begin errors++; $display("FAIL single_first got %0d want %0d", t_first - t_hs, 2); end
      checks++; if (beats != 4 || lasts != 1 || t_last != t_hs + 5) begin errors++; $display("FAIL single_beats got %0d last@%0d want 4 last@5", beats, t_last - t_hs); end
      checks++; if (t_done != t_hs + 9) begin errors++; $display("FAIL single_done_time got %0d want 9", t_done - t_hs); end
      check_done_pop("single");
      checks++; if (busy_after !== 1'b0 || cfg_after !== 1'b0 || msel_after !== 8'h0 || done_after !== 1'b0) begin errors++; $display("FAIL single_idle got busy %b cfg %b msel %h done %b want 0", busy_after, cfg_after, msel_after, done_after); end
   endtask

   task automatic test_beat_gaps();
      sb.push_back('{1, 8'h44, 8'h55});
      run_job(1, 8'h44, 8'h55, 8'd2, 1'b1, 4'h0);
      checks++; if (beats != 3) begin errors++; $display("FAIL gaps_beats got %0d want 3", beats); end
      checks++; if (lasts != 1 || last_no != 3) begin errors++; $display("FAIL gaps_last got %0d on beat %0d want 1 on beat 3", lasts, last_no); end
      checks++; if (t_last != t_hs + 6 || t_done != t_last + PIPE_LAT) begin errors++; $display("FAIL gaps_time got last %0d done %0d want 6 10", t_last - t_hs, t_done - t_hs); end
      check_done_pop("gaps");
   endtask

   task automatic test_len255();
      sb.push_back('{3, 8'hA5, 8'h5A});
      run_job(3, 8'hA5, 8'h5A, 8'd255, 1'b0, 4'h0);
      checks++; if (beats != 256 || lasts != 1 || last_no != 256) begin errors++; $display("FAIL len255_beats got %0d last %0d on %0d want 256 1 256", beats, lasts, last_no); end
      checks++; if (t_done != t_hs + 1 + CFG_LAT + 256 + PIPE_LAT - 1) begin errors++; $display("FAIL len255_done got %0d want %0d", t_done - t_hs, 1 + CFG_LAT + 256 + PIPE_LAT - 1); end
      check_done_pop("len255");
   endtask

   task automatic test_drain_request();
      int l;
      set_req(0, 8'h66, 8'h77, 8'd1);
      sb.push_back('{2, 8'h31, 8'h32});
      run_job(2, 8'h31, 8'h32, 8'd1, 1'b0, 4'b0001);
      l = t_last;
      checks++; if (ready_early) begin errors++; $display("FAIL drain_ready got early req_ready want 0"); end
      checks++; if (sel_chg) begin errors++; $display("FAIL drain_sel got change want stable %h/%h", s_msel, s_ssel); end
      check_done_pop("drain_a");
      sb.push_back('{0, 8'h66, 8'h77});
      run_job(0, 8'h66, 8'h77, 8'd1, 1'b0, 4'h0);
      checks++; if (t_hs != l + PIPE_LAT + 1) begin errors++; $display("FAIL drain_next_hs got %0d want %0d", t_hs - l, PIPE_LAT + 1); end
      check_done_pop("drain_b");
   endtask

   task automatic test_reset_mid();
      int nb;
      int got;
      bit seen_done;
      logic [3:0] first_g;
      logic [3:0] clr;
      nb = 0; got = 0; seen_done = 0; first_g = '0;
      set_req(0, 8'h70, 8'h71, 8'd0);
      set_req(3, 8'h73, 8'h74, 8'd0);
      set_req(1, 8'h61, 8'h62, 8'd4);
      bus.req_valid = 4'b0010;
      for (int n = 0; n < 20; n++) begin
         #1;
         if (bus.req_ready[1]) break;
         tick();
      end
      tick();
      bus.req_valid = 4'b1001;
      bus.dat_valid = 1'b1;
      for (int n = 0; n < 20 && nb < 2; n++) begin
         #1;
         if (bus.dat_valid && bus.dat_ready) nb++;
         if (bus.o_done) seen_done = 1;
         tick();
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.o_cfg_valid !== 1'b0 || bus.o_grant !== 4'h0 || bus.dat_ready !== 1'b0 ||
          bus.o_busy !== 1'b0 || bus.o_module_select !== 8'h0 || bus.req_ready !== 4'h0) begin
         errors++;
         $display("FAIL abort_outputs got cfg %b grant %h rdy %b busy %b msel %h rr %h want 0",
                  bus.o_cfg_valid, bus.o_grant, bus.dat_ready, bus.o_busy,
                  bus.o_module_select, bus.req_ready);
      end
      tick();
      if (bus.o_done) seen_done = 1;
      tick();
      if (bus.o_done) seen_done = 1;
      rst = 1'b0;
      sb.push_back('{0, 8'h70, 8'h71});
      sb.push_back('{3, 8'h73, 8'h74});
      for (int n = 0; n < 100 && got < 2; n++) begin
         #1;
         clr = bus.req_ready;
         if (|clr && first_g == '0) first_g = clr;
         if (bus.o_done) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL abort_done unexpected id %0d", bus.o_done_id);
            end else begin
               e = sb.pop_front();
               if (int'(bus.o_done_id) != e.id || bus.o_module_select !== e.msel) begin
                  errors++;
                  $display("FAIL abort_done got id %0d msel %h want id %0d msel %h",
                           bus.o_done_id, bus.o_module_select, e.id, e.msel);
               end
            end
            got++;
         end
         tick();
         bus.req_valid = bus.req_valid & ~clr;
      end
      bus.dat_valid = 1'b0;
      checks++; if (nb != 2) begin errors++; $display("FAIL abort_prebeats got %0d want 2", nb); end
      checks++; if (seen_done) begin errors++; $display("FAIL abort_no_done got pulse want none"); end
      checks++; if (first_g !== 4'b0001) begin errors++; $display("FAIL abort_regrant got %b want 0001", first_g); end
      checks++; if (got != 2) begin errors++; $display("FAIL abort_timeout got %0d dones want 2", got); end
   endtask

   initial begin
      bus.req_valid = '0;
      bus.req_msel  = '0;
      bus.req_ssel  = '0;
      bus.req_len   = '0;
      bus.dat_valid = 1'b0;
      test_reset();
      test_round_robin();
      test_single();
      test_beat_gaps();
      test_len255();
      test_drain_request();
      test_reset_mid();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_left got %0d entries want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
